// File: rtl/thd_ratio_engine.sv
// Harmonic-distortion front end: per frame, latches the fundamental bin, sums the harmonic bins,
// then takes rounded, saturated square roots of both with one shared restoring root sequencer.
module thd_ratio_engine #(
    parameter int DATA_W     = 24,
    parameter int FRAME_LEN  = 8,
    parameter int FUND_BIN   = 1,
    parameter int HARM_FIRST = 2,
    parameter int NUM_HARM   = 4,
    localparam int SUM_W     = DATA_W + $clog2(NUM_HARM),
    localparam int ROOT_W    = (SUM_W + 1) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic [ROOT_W-1:0] thd_numer,
    output logic [ROOT_W-1:0] thd_denom,
    output logic              thd_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int RAD_W = 2 * ROOT_W;
    localparam int REM_W = ROOT_W + 3;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int IT_W  = $clog2(ROOT_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ROOT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]    harm_q, harm_d;
    logic [DATA_W-1:0]   fund_q, fund_d;
    logic [IT_W-1:0]     iter_q, iter_d;
    logic [RAD_W-1:0]    nrad_q, nrad_d, drad_q, drad_d;
    logic [REM_W-1:0]    nrem_q, nrem_d, drem_q, drem_d;
    logic [ROOT_W-1:0]   nroot_q, nroot_d, droot_q, droot_d;
    logic [ROOT_W-1:0]   numer_q, numer_d, denom_q, denom_d;
    logic                err_q, err_d, ovr_q, ovr_d;
    logic [CNT_W-1:0]    bin_idx;
    logic                is_last;

    // One restoring digit: bring down two radicand bits, try subtracting (4q+1).
    function automatic logic [REM_W+ROOT_W-1:0] sqrt_step(input logic [REM_W-1:0] rem,
                                                          input logic [ROOT_W-1:0] root,
                                                          input logic [1:0] pair);
        logic [REM_W-1:0] cur;
        logic [REM_W-1:0] trial;
        cur   = {rem[REM_W-3:0], pair};
        trial = {1'b0, root, 2'b01};
        if (cur >= trial)
            return {cur - trial, root[ROOT_W-2:0], 1'b1};
        return {cur, root[ROOT_W-2:0], 1'b0};
    endfunction

    // Remainder above q means the true root is past q+0.5.
    function automatic logic [ROOT_W-1:0] round_sat(input logic [REM_W-1:0] rem,
                                                    input logic [ROOT_W-1:0] root);
        if (rem > {3'b000, root}) begin
            if (&root)
                return root;
            return root + ROOT_W'(1);
        end
        return root;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            harm_q  <= '0;
            fund_q  <= '0;
            iter_q  <= '0;
            nrad_q  <= '0;
            drad_q  <= '0;
            nrem_q  <= '0;
            drem_q  <= '0;
            nroot_q <= '0;
            droot_q <= '0;
            numer_q <= '0;
            denom_q <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            harm_q  <= harm_d;
            fund_q  <= fund_d;
            iter_q  <= iter_d;
            nrad_q  <= nrad_d;
            drad_q  <= drad_d;
            nrem_q  <= nrem_d;
            drem_q  <= drem_d;
            nroot_q <= nroot_d;
            droot_q <= droot_d;
            numer_q <= numer_d;
            denom_q <= denom_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        harm_d  = harm_q;
        fund_d  = fund_q;
        iter_d  = iter_q;
        nrad_d  = nrad_q;
        drad_d  = drad_q;
        nrem_d  = nrem_q;
        drem_d  = drem_q;
        nroot_d = nroot_q;
        droot_d = droot_q;
        numer_d = numer_q;
        denom_d = denom_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        bin_idx = in_sop ? '0 : cnt_q;
        is_last = (bin_idx == CNT_W'(FRAME_LEN - 1));

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (in_valid && (in_sop || state_q == S_COLLECT)) begin
                    if (in_sop) begin
                        harm_d = '0;
                        fund_d = '0;
                    end
                    if (bin_idx == CNT_W'(FUND_BIN))
                        fund_d = in_data;
                    if (bin_idx >= CNT_W'(HARM_FIRST) && bin_idx < CNT_W'(HARM_FIRST + NUM_HARM))
                        harm_d = harm_d + SUM_W'(in_data);
                    if (in_eop && is_last) begin
                        state_d = S_ROOT;
                        cnt_d   = '0;
                        iter_d  = '0;
                        nrad_d  = RAD_W'(harm_d);
                        drad_d  = RAD_W'(fund_d);
                        nrem_d  = '0;
                        drem_d  = '0;
                        nroot_d = '0;
                        droot_d = '0;
                    end else if (in_eop || is_last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                        cnt_d   = bin_idx + CNT_W'(1);
                    end
                end
            end
            S_ROOT: begin
                ovr_d = in_valid && in_sop;
                {nrem_d, nroot_d} = sqrt_step(nrem_q, nroot_q, nrad_q[RAD_W-1 -: 2]);
                {drem_d, droot_d} = sqrt_step(drem_q, droot_q, drad_q[RAD_W-1 -: 2]);
                nrad_d = nrad_q << 2;
                drad_d = drad_q << 2;
                iter_d = iter_q + IT_W'(1);
                if (iter_q == IT_W'(ROOT_W - 1)) begin
                    state_d = S_DONE;
                    numer_d = round_sat(nrem_d, nroot_d);
                    denom_d = round_sat(drem_d, droot_d);
                end
            end
            S_DONE: begin
                ovr_d   = in_valid && in_sop;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        thd_valid = (state_q == S_DONE);
        busy      = (state_q == S_ROOT) || (state_q == S_DONE);
        thd_numer = numer_q;
        thd_denom = denom_q;
        frame_err = err_q;
        overrun   = ovr_q;
    end

endmodule

// File: tb/tb_thd_ratio_engine.sv
// Scoreboard bench for thd_ratio_engine: stimulus queues timed expected events, a monitor matches strobes.
module tb_thd_ratio_engine;

    localparam int DATA_W = 24;
    localparam int ROOT_W = 13;
    localparam int MAXB   = 32'hFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sop = 1'b0;
    logic              in_eop = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [ROOT_W-1:0] thd_numer, thd_denom;
    logic              thd_valid, busy, frame_err, overrun;

    thd_ratio_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .thd_numer(thd_numer), .thd_denom(thd_denom),
        .thd_valid(thd_valid), .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; int numer; int denom; } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int last_cyc = 0;

    // Keep the queue ordered by the cycle each event is due.
    task automatic push_exp(input int kind, input int at, input int numer, input int denom);
        exp_t e;
        int idx;
        e.kind = kind; e.cyc = at; e.numer = numer; e.denom = denom;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic match(input int kind);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d numer=%0d denom=%0d (none expected)",
                     kind, cyc, thd_numer, thd_denom);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != cyc ||
            (kind == 0 && (int'(thd_numer) != e.numer || int'(thd_denom) != e.denom))) begin
            n_bad++;
            $display("FAIL event got kind=%0d cyc=%0d numer=%0d denom=%0d, want kind=%0d cyc=%0d numer=%0d denom=%0d",
                     kind, cyc, thd_numer, thd_denom, e.kind, e.cyc, e.numer, e.denom);
        end
    endtask

    always @(negedge clk) begin
        if (thd_valid) match(0);
        if (frame_err) match(1);
        if (overrun)   match(2);
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input int d);
        @(posedge clk);
        #1;
        in_valid = v; in_sop = s; in_eop = e; in_data = d[DATA_W-1:0];
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic send_frame(input int b[8], input int n, input bit with_eop, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) drive(0, 1, 1, 32'h55);
            drive(1, i == 0, with_eop && (i == n - 1), b[i]);
        end
    endtask

    task automatic sample_outputs(input string tag, input int numer, input int denom);
        @(negedge clk);
        check({tag, "_numer"}, int'(thd_numer), numer);
        check({tag, "_denom"}, int'(thd_denom), denom);
        check({tag, "_valid"}, int'(thd_valid), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_ferr"},  int'(frame_err), 0);
        check({tag, "_ovr"},   int'(overrun), 0);
    endtask

    int f1[8]   = '{0, 10000, 25, 36, 49, 64, 0, 0};
    int f182[8] = '{0, 10000, 49, 49, 49, 35, 0, 0};
    int f183[8] = '{0, 10000, 49, 49, 49, 36, 0, 0};
    int fmax[8] = '{MAXB, MAXB, MAXB, MAXB, MAXB, MAXB, MAXB, MAXB};
    int fjunk[8] = '{7, 8, 9, 10, 11, 12, 13, 14};
    int c;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        sample_outputs("reset", 0, 0);
        #1 rst = 1'b0;
        idle(2);

        // basic frame and busy during root
        send_frame(f1, 8, 1, 0);
        push_exp(0, last_cyc + 14, 13, 100);
        idle(1);
        @(negedge clk);
        check("busy_in_root", int'(busy), 1);
        idle(16);

        // rounding boundary: remainder equal to q vs one above
        send_frame(f182, 8, 1, 0);
        push_exp(0, last_cyc + 14, 13, 100);
        idle(16);
        send_frame(f183, 8, 1, 0);
        push_exp(0, last_cyc + 14, 14, 100);
        idle(16);

        // saturation, then the same frame with in_valid gaps
        send_frame(fmax, 8, 1, 0);
        push_exp(0, last_cyc + 14, 8191, 4096);
        idle(16);
        send_frame(fmax, 8, 1, 1);
        push_exp(0, last_cyc + 14, 8191, 4096);
        idle(16);

        // length faults: early eop, then missing eop
        send_frame(f1, 6, 1, 0);
        push_exp(1, last_cyc + 1, 0, 0);
        idle(3);
        @(negedge clk);
        check("held_numer", int'(thd_numer), 8191);
        check("held_denom", int'(thd_denom), 4096);
        send_frame(f1, 8, 0, 0);
        push_exp(1, last_cyc + 1, 0, 0);
        idle(16);

        // sop while busy is dropped, first frame still completes
        send_frame(f1, 8, 1, 0);
        c = last_cyc;
        push_exp(0, c + 14, 13, 100);
        push_exp(2, c + 4, 0, 0);
        idle(2);
        send_frame(fjunk, 8, 1, 0);
        idle(8);
        send_frame(f183, 8, 1, 0);
        push_exp(0, last_cyc + 14, 14, 100);
        idle(16);

        // reset during root aborts and clears results
        send_frame(f182, 8, 1, 0);
        idle(5);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sample_outputs("rst_mid_root", 0, 0);
        idle(16);
        send_frame(f1, 8, 1, 0);
        push_exp(0, last_cyc + 14, 13, 100);
        idle(16);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event kind=%0d due_cyc=%0d numer=%0d denom=%0d", e.kind, e.cyc, e.numer, e.denom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
